// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared definitions for the Z80 bus initiator.
//   - cycle-type encodings carried on req_type
//   - bus phase state enum (one state per half T-state)
//   - default wait-state limit
package z80_bus_pkg;

  localparam logic [2:0] CYC_M1    = 3'd0;
  localparam logic [2:0] CYC_MEMRD = 3'd1;
  localparam logic [2:0] CYC_MEMWR = 3'd2;
  localparam logic [2:0] CYC_IORD  = 3'd3;
  localparam logic [2:0] CYC_IOWR  = 3'd4;

  localparam int WAIT_MAX_DEF = 255;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_T1H  = 4'd1,
    PH_T1L  = 4'd2,
    PH_T2H  = 4'd3,
    PH_T2L  = 4'd4,
    PH_TWH  = 4'd5,
    PH_TWL  = 4'd6,
    PH_T3H  = 4'd7,
    PH_T3L  = 4'd8,
    PH_T4H  = 4'd9,
    PH_T4L  = 4'd10
  } phase_e;

  function automatic logic cyc_is_io(input logic [2:0] t);
    return (t == CYC_IORD) || (t == CYC_IOWR);
  endfunction

  function automatic logic cyc_is_rd(input logic [2:0] t);
    return (t == CYC_M1) || (t == CYC_MEMRD) || (t == CYC_IORD);
  endfunction

endpackage

// File: rtl/z80_bus_initiator_wait_timer.sv
// z80_wait_timer: counts wait states inserted by wait_n within one bus cycle.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the count (issued as the cycle enters T1H)
//   inc        : one more counted wait state is starting
//   timeout    : WAIT_MAX wait states already counted; another one must abort
module z80_wait_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_MAX + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CW'(WAIT_MAX));

endmodule

// File: rtl/z80_bus_initiator.sv
// z80_bus_initiator: turns valid/ready requests into sequenced Z80 bus cycles
// (M1 fetch + refresh, memory read/write, I/O read/write). One clk is one
// half T-state. All outputs are registered; the value set on the edge that
// enters a phase is what the bus shows during that phase.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_type/addr/wdata    : cycle type (0..4 legal), address, write data
//   rsp_valid/err/rdata    : one-clk completion pulse, error flag, read data
//   addr/data_out/data_oe  : bus address, write data and its drive enable
//   data_in, wait_n        : bus read data, wait request (low = wait)
//   mreq_n..refresh_n      : active-low bus strobes
module z80_bus_initiator
  import z80_bus_pkg::*;
#(
  parameter int         WAIT_MAX   = WAIT_MAX_DEF,
  parameter logic [7:0] REFRESH_HI = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        m1_n,
  output logic        refresh_n,
  input  logic        wait_n
);

  phase_e      state_q, state_d;
  logic [2:0]  typ_q, typ_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d;
  logic        rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic        m1_n_q, m1_n_d, refresh_n_q, refresh_n_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [7:0]  cap_q, cap_d;
  logic [6:0]  r_q, r_d;
  logic        req_ready_q, req_ready_d;

  logic tmr_clr, tmr_inc, tmr_timeout;
  logic is_m1, is_io, is_rd;

  assign is_m1 = (typ_q == CYC_M1);
  assign is_io = cyc_is_io(typ_q);
  assign is_rd = cyc_is_rd(typ_q);

  z80_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .timeout(tmr_timeout)
  );

  always_comb begin
    state_d     = state_q;
    typ_d       = typ_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    mreq_n_d    = mreq_n_q;
    iorq_n_d    = iorq_n_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    m1_n_d      = m1_n_q;
    refresh_n_d = refresh_n_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cap_d       = cap_q;
    r_d         = r_q;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;

    unique case (state_q)
      PH_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_type > CYC_IOWR) begin
            // Illegal type: answer immediately, never touch the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            typ_d   = req_type;
            wdata_d = req_wdata;
            addr_d  = req_addr;
            m1_n_d  = (req_type != CYC_M1);
            tmr_clr = 1'b1;
            state_d = PH_T1H;
          end
        end
      end
      PH_T1H: begin
        state_d = PH_T1L;
        if (!is_io) begin
          mreq_n_d = 1'b0;
          if (is_rd) rd_n_d = 1'b0;
          if (typ_q == CYC_MEMWR) begin
            data_oe_d  = 1'b1;
            data_out_d = wdata_q;
          end
        end
      end
      PH_T1L: begin
        state_d = PH_T2H;
        if (is_io) begin
          iorq_n_d = 1'b0;
          if (typ_q == CYC_IORD) rd_n_d = 1'b0;
          else begin
            wr_n_d     = 1'b0;
            data_oe_d  = 1'b1;
            data_out_d = wdata_q;
          end
        end
      end
      PH_T2H: begin
        state_d = PH_T2L;
        if (typ_q == CYC_MEMWR) wr_n_d = 1'b0;
      end
      PH_T2L, PH_TWL: begin
        if (state_q == PH_T2L && is_io) begin
          // Automatic I/O wait; wait_n ignored and not counted.
          state_d = PH_TWH;
        end else if (!wait_n) begin
          if (tmr_timeout) begin
            mreq_n_d    = 1'b1;
            iorq_n_d    = 1'b1;
            rd_n_d      = 1'b1;
            wr_n_d      = 1'b1;
            m1_n_d      = 1'b1;
            refresh_n_d = 1'b1;
            data_oe_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = PH_IDLE;
          end else begin
            tmr_inc = 1'b1;
            state_d = PH_TWH;
          end
        end else begin
          state_d = PH_T3H;
          if (is_m1) begin
            // Opcode is latched as the fetch half ends; refresh begins.
            cap_d       = data_in;
            mreq_n_d    = 1'b1;
            rd_n_d      = 1'b1;
            m1_n_d      = 1'b1;
            refresh_n_d = 1'b0;
            addr_d      = {REFRESH_HI, 1'b0, r_q};
          end
        end
      end
      PH_TWH: state_d = PH_TWL;
      PH_T3H: begin
        state_d = PH_T3L;
        if (is_m1) mreq_n_d = 1'b0;
        else if (is_rd) cap_d = data_in;
      end
      PH_T3L: begin
        if (is_m1) state_d = PH_T4H;
        else begin
          mreq_n_d    = 1'b1;
          iorq_n_d    = 1'b1;
          rd_n_d      = 1'b1;
          wr_n_d      = 1'b1;
          data_oe_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (is_rd) rsp_rdata_d = cap_q;
          state_d     = PH_IDLE;
        end
      end
      PH_T4H: begin
        state_d  = PH_T4L;
        mreq_n_d = 1'b1;
      end
      PH_T4L: begin
        refresh_n_d = 1'b1;
        r_d         = r_q + 7'd1;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cap_q;
        state_d     = PH_IDLE;
      end
      default: state_d = PH_IDLE;
    endcase

    req_ready_d = (state_d == PH_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PH_IDLE;
      typ_q       <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      mreq_n_q    <= 1'b1;
      iorq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      m1_n_q      <= 1'b1;
      refresh_n_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cap_q       <= '0;
      r_q         <= '0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      typ_q       <= typ_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      mreq_n_q    <= mreq_n_d;
      iorq_n_q    <= iorq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      m1_n_q      <= m1_n_d;
      refresh_n_q <= refresh_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cap_q       <= cap_d;
      r_q         <= r_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addr      = addr_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign mreq_n    = mreq_n_q;
  assign iorq_n    = iorq_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign m1_n      = m1_n_q;
  assign refresh_n = refresh_n_q;

endmodule

// File: tb/tb_z80_bus_initiator.sv
// Bench for z80_bus_initiator: each transaction's expected phase sequence is
// built from the bus-cycle rules (phase list + per-phase strobe table), and
// every clk of the transaction is compared against it.
module tb_z80_bus_initiator;

  localparam int         WMAX = 4;
  localparam logic [7:0] RHI  = 8'h00;

  // Phase codes local to the bench.
  localparam int P_T1H = 0, P_T1L = 1, P_T2H = 2, P_T2L = 3, P_TWH = 4, P_TWL = 5;
  localparam int P_T3H = 6, P_T3L = 7, P_T4H = 8, P_T4L = 9, P_IDLE = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, refresh_n;
  logic        wait_n;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state.
  logic [15:0] m_addr;
  logic [6:0]  m_r;
  logic [7:0]  m_rdata;

  always #5 clk = ~clk;

  z80_bus_initiator #(.WAIT_MAX(WMAX), .REFRESH_HI(RHI)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .addr(addr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .refresh_n(refresh_n), .wait_n(wait_n)
  );

  function automatic logic inr(input int p, input int lo, input int hi);
    return (p >= lo) && (p <= hi);
  endfunction

  // Active (1 = asserted) {mreq, iorq, rd, wr, m1, rfsh, oe} for a type/phase.
  function automatic logic [6:0] exp_vec(input logic [2:0] t, input int p);
    logic mq, iq, rd, wr, m1, rf, oe;
    mq = 0; iq = 0; rd = 0; wr = 0; m1 = 0; rf = 0; oe = 0;
    case (t)
      3'd0: begin
        m1 = inr(p, 0, 5);
        mq = inr(p, 1, 5) || p == P_T3L || p == P_T4H;
        rd = inr(p, 1, 5);
        rf = inr(p, 6, 9);
      end
      3'd1: begin mq = inr(p, 1, 7); rd = inr(p, 1, 7); end
      3'd2: begin mq = inr(p, 1, 7); wr = inr(p, 3, 7); oe = inr(p, 1, 7); end
      3'd3: begin iq = inr(p, 2, 7); rd = inr(p, 2, 7); end
      3'd4: begin iq = inr(p, 2, 7); wr = inr(p, 2, 7); oe = inr(p, 2, 7); end
      default: ;
    endcase
    return {mq, iq, rd, wr, m1, rf, oe};
  endfunction

  function automatic logic [6:0] got_vec();
    return {~mreq_n, ~iorq_n, ~rd_n, ~wr_n, ~m1_n, ~refresh_n, data_oe};
  endfunction

  // Runs one legal transaction from an IDLE negedge; returns at the negedge
  // of the rsp_valid clk so the next call can start back-to-back.
  task automatic run_txn(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rdv, input int waits, input string tag);
    int ph[$];
    int L, cap_k, nw, lows, cur, prev;
    bit io, m1, rdt, tmo;
    logic [6:0]  ev;
    logic [15:0] ea, fin_addr;
    io  = (t == 3'd3) || (t == 3'd4);
    m1  = (t == 3'd0);
    rdt = (t == 3'd0) || (t == 3'd1) || (t == 3'd3);
    tmo = (waits > WMAX);
    nw  = tmo ? WMAX : waits;
    ph = '{P_T1H, P_T1L, P_T2H, P_T2L};
    if (io) begin ph.push_back(P_TWH); ph.push_back(P_TWL); end
    for (int i = 0; i < nw; i++) begin ph.push_back(P_TWH); ph.push_back(P_TWL); end
    if (!tmo) begin
      ph.push_back(P_T3H); ph.push_back(P_T3L);
      if (m1) begin ph.push_back(P_T4H); ph.push_back(P_T4L); end
    end
    L = ph.size();
    cap_k = -1;
    for (int i = 0; i < L; i++)
      if ((m1 && ph[i] == P_T3H) || (!m1 && rdt && ph[i] == P_T3L)) cap_k = i;
    fin_addr = (m1 && !tmo) ? {RHI, 1'b0, m_r} : a;

    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before_accept got %b exp 1", tag, req_ready);
    end
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
    wait_n = 1'($urandom); data_in = 8'($urandom);
    @(posedge clk); #1;
    req_valid = 1'b0; req_type = 3'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
    lows = 0;
    for (int k = 0; k <= L; k++) begin
      if (k > 0) begin
        prev = ph[k-1];
        if ((prev == P_T2L && !io) || prev == P_TWL) begin
          wait_n = (lows < waits) ? 1'b0 : 1'b1;
          if (lows < waits) lows++;
        end else wait_n = 1'($urandom);
        data_in = (k == cap_k) ? rdv : ~rdv;
        @(posedge clk);
      end
      @(negedge clk);
      cur = (k < L) ? ph[k] : P_IDLE;
      ev  = exp_vec(t, cur);
      n_chk++;
      if (got_vec() !== ev) begin
        n_fail++; $display("FAIL %s strobes k=%0d got %b exp %b", tag, k, got_vec(), ev);
      end
      if (m1 && inr(cur, P_T3H, P_T4L)) ea = {RHI, 1'b0, m_r};
      else if (k < L)                   ea = a;
      else                              ea = fin_addr;
      n_chk++;
      if (addr !== ea) begin
        n_fail++; $display("FAIL %s addr k=%0d got %h exp %h", tag, k, addr, ea);
      end
      if (ev[0]) begin
        n_chk++;
        if (data_out !== wd) begin
          n_fail++; $display("FAIL %s data_out k=%0d got %h exp %h", tag, k, data_out, wd);
        end
      end
      n_chk++;
      if (rsp_valid !== (k == L) || req_ready !== (k == L)) begin
        n_fail++;
        $display("FAIL %s rsp_valid/ready k=%0d got %b/%b exp %b", tag, k, rsp_valid, req_ready, k == L);
      end
      if (k == L) begin
        n_chk++;
        if (rsp_err !== tmo) begin
          n_fail++; $display("FAIL %s rsp_err got %b exp %b", tag, rsp_err, tmo);
        end
        n_chk++;
        if (rsp_rdata !== ((rdt && !tmo) ? rdv : m_rdata)) begin
          n_fail++;
          $display("FAIL %s rsp_rdata got %h exp %h", tag, rsp_rdata, (rdt && !tmo) ? rdv : m_rdata);
        end
      end
    end
    m_addr = fin_addr;
    if (m1 && !tmo) m_r = m_r + 7'd1;
    if (rdt && !tmo) m_rdata = rdv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0; wait_n = 1'($urandom); data_in = 8'($urandom);
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0 || got_vec() !== 7'd0 || req_ready !== 1'b1 || addr !== m_addr) begin
        n_fail++;
        $display("FAIL idle got rsp=%b str=%b rdy=%b addr=%h exp 0/0/1/%h",
                 rsp_valid, got_vec(), req_ready, addr, m_addr);
      end
    end
  endtask

  task automatic do_illegal(input logic [2:0] t);
    req_valid = 1'b1; req_type = t; req_addr = 16'($urandom); req_wdata = 8'($urandom);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL illegal rsp got %b/%b exp 1/1", rsp_valid, rsp_err);
    end
    n_chk++;
    if (got_vec() !== 7'd0 || addr !== m_addr || rsp_rdata !== m_rdata || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal bus got str=%b addr=%h rdata=%h rdy=%b exp 0/%h/%h/1",
               got_vec(), addr, rsp_rdata, req_ready, m_addr, m_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_type = '0; req_addr = '0; req_wdata = '0;
    data_in = '0; wait_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_addr = '0; m_r = '0; m_rdata = '0;
    n_chk++;
    if (got_vec() !== 7'd0 || addr !== 16'h0 || data_out !== 8'h0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_rdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_values got str=%b addr=%h dout=%h rv=%b re=%b rd=%h exp all idle/zero",
               got_vec(), addr, data_out, rsp_valid, rsp_err, rsp_rdata);
    end
    idle(1);
  endtask

  task automatic test_mem_read();   run_txn(3'd1, 16'h1234, 8'h00, 8'hA5, 0, "memrd"); idle(1); endtask
  task automatic test_io_write();   run_txn(3'd4, 16'h0044, 8'h3C, 8'h00, 0, "iowr");  idle(1); endtask
  task automatic test_mem_write();  run_txn(3'd2, 16'hBEEF, 8'h5A, 8'h00, 0, "memwr"); idle(1); endtask
  task automatic test_io_read();    run_txn(3'd3, 16'h00FE, 8'h00, 8'h77, 1, "iord");  idle(1); endtask

  task automatic test_m1();
    // R starts at 0 after reset: refresh addresses 0x0000 then 0x0001.
    run_txn(3'd0, 16'h0100, 8'h00, 8'hC3, 0, "m1_a");
    run_txn(3'd0, 16'h0100, 8'h00, 8'hC3, 0, "m1_b");
    idle(1);
  endtask

  task automatic test_waits();
    run_txn(3'd1, 16'h4000, 8'h00, 8'h96, 3, "memrd_w3");
    run_txn(3'd0, 16'h2000, 8'h00, 8'h3E, 2, "m1_w2");
    idle(1);
  endtask

  task automatic test_timeout();
    run_txn(3'd1, 16'h8000, 8'h00, 8'h11, WMAX + 3, "tmo_memrd");
    run_txn(3'd4, 16'h0010, 8'hE1, 8'h00, WMAX + 1, "tmo_iowr");
    run_txn(3'd1, 16'h8001, 8'h00, 8'h22, WMAX, "memrd_wmax");
    idle(1);
  endtask

  task automatic test_illegal();
    do_illegal(3'd6);
    idle(1);
    do_illegal(3'd5);
    do_illegal(3'd7);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_txn(3'd2, 16'h1111, 8'hAA, 8'h00, 0, "b2b_0");
    run_txn(3'd3, 16'h0022, 8'h00, 8'h55, 0, "b2b_1");
    run_txn(3'd0, 16'h3333, 8'h00, 8'h44, 1, "b2b_2");
    run_txn(3'd1, 16'h4444, 8'h00, 8'h66, 0, "b2b_3");
    idle(1);
  endtask

  task automatic test_random();
    logic [2:0] t;
    int w;
    for (int i = 0; i < 80; i++) begin
      t = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 9) == 0) ? WMAX + 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      if (t > 3'd4) do_illegal(t);
      else run_txn(t, 16'($urandom), 8'($urandom), 8'($urandom), w, "rand");
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_type = 3'd3; req_addr = 16'h00A0; req_wdata = 8'h00;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);   // now in T2L
    @(negedge clk);
    n_chk++;
    if (got_vec() !== exp_vec(3'd3, P_T2L)) begin
      n_fail++; $display("FAIL mid_pre_reset got %b exp %b", got_vec(), exp_vec(3'd3, P_T2L));
    end
    reset = 1'b1; wait_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (got_vec() !== 7'd0 || rsp_valid !== 1'b0 || addr !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset got str=%b rv=%b addr=%h exp 0/0/0000", got_vec(), rsp_valid, addr);
    end
    reset = 1'b0;
    m_addr = '0; m_r = '0; m_rdata = '0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_after got rv=%b rdy=%b exp 0/1", rsp_valid, req_ready);
    end
    // Refresh address must come from the cleared R counter.
    run_txn(3'd0, 16'h0F00, 8'h00, 8'h00, 0, "m1_after_reset");
    idle(1);
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_m1();
    test_io_write();
    test_mem_write();
    test_io_read();
    test_waits();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
